// File: rtl/uart_rx_engine_if.sv
// Receive-side bundle of the UART receiver.
//   rxd        serial line into the receiver (idle high)
//   rx_data    received byte, LSB = first bit on the line
//   rx_valid   rx_data and flags are valid
//   rx_ready   consumer accepts when rx_valid && rx_ready
//   frame_err  stop bit of the held byte was low
//   parity_err parity mismatch on the held byte
//   overrun    one-cycle pulse: a completed frame was dropped
//   busy       receiver is inside a frame
// master: the receiver; slave: line driver / byte consumer.
interface uart_rx_engine_if;
  logic       rxd;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       parity_err;
  logic       overrun;
  logic       busy;

  modport master (
    input  rxd, rx_ready,
    output rx_data, rx_valid, frame_err, parity_err, overrun, busy
  );

  modport slave (
    output rxd, rx_ready,
    input  rx_data, rx_valid, frame_err, parity_err, overrun, busy
  );
endinterface

// File: rtl/uart_rx_engine.sv
// UART receiver: deserialises 1-start / DATA_BITS / optional parity / 1-stop frames into bytes
// with a valid/ready handshake, per-byte framing/parity flags and an overrun pulse.
// Ports:
//   clk_clk      system clock, rising edge
//   reset_reset  asynchronous active-high reset
//   bus          uart_rx_engine_if.master (rxd, rx_ready in; byte, flags, overrun, busy out)
module uart_rx_engine #(
  parameter int unsigned CLK_HZ    = 50000000,
  parameter int unsigned BAUD      = 115200,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PARITY    = 0
) (
  input logic               clk_clk,
  input logic               reset_reset,
  uart_rx_engine_if.master  bus
);

  localparam int unsigned CPB   = CLK_HZ / BAUD;
  localparam int unsigned CNT_W = $clog2(CPB);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CPB - 1);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(CPB / 2 - 1);
  localparam logic [2:0]       BIT_LAST = 3'(DATA_BITS - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop, StWaitHigh} state_e;

  state_e               state_q;
  logic [1:0]           sync_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [2:0]           bit_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 par_q;
  logic                 stop_q;
  logic                 commit_q;
  logic [7:0]           rx_data_q;
  logic                 rx_valid_q;
  logic                 frame_err_q;
  logic                 parity_err_q;
  logic                 overrun_q;
  logic                 rxs;
  logic                 par_exp;

  assign rxs = sync_q[1];

  // Expected parity bit for the assembled payload; odd mode inverts the even-mode XOR.
  always_comb begin
    par_exp = ^shift_q;
    if (PARITY == 1) par_exp = ~par_exp;
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state_q      <= StIdle;
      sync_q       <= 2'b11;
      cnt_q        <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      par_q        <= 1'b0;
      stop_q       <= 1'b0;
      commit_q     <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], bus.rxd};
      cnt_q     <= cnt_q + 1'b1;
      overrun_q <= 1'b0;

      case (state_q)
        StIdle: begin
          cnt_q <= '0;
          if (!rxs) state_q <= StStart;
        end
        StStart: begin
          if (cnt_q == CNT_MID) begin
            cnt_q   <= '0;
            bit_q   <= '0;
            // A high line at mid start bit is a glitch, not a frame.
            state_q <= rxs ? StIdle : StData;
          end
        end
        StData: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q   <= '0;
            shift_q <= {rxs, shift_q[DATA_BITS-1:1]};
            bit_q   <= bit_q + 1'b1;
            if (bit_q == BIT_LAST) state_q <= (PARITY != 0) ? StParity : StStop;
          end
        end
        StParity: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q   <= '0;
            par_q   <= rxs;
            state_q <= StStop;
          end
        end
        StStop: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q    <= '0;
            stop_q   <= rxs;
            commit_q <= 1'b1;
            // A low stop (framing error or break) must see the line recover before re-arming.
            state_q  <= rxs ? StIdle : StWaitHigh;
          end
        end
        StWaitHigh: begin
          cnt_q <= '0;
          if (rxs) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase

      if (rx_valid_q && bus.rx_ready) rx_valid_q <= 1'b0;

      // Commit one cycle after the stop sample; an accept in the same cycle frees the slot.
      if (commit_q) begin
        commit_q <= 1'b0;
        if (!rx_valid_q || bus.rx_ready) begin
          rx_data_q    <= 8'(shift_q);
          frame_err_q  <= ~stop_q;
          parity_err_q <= (PARITY != 0) && (par_q != par_exp);
          rx_valid_q   <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end
    end
  end

  assign bus.rx_data    = rx_data_q;
  assign bus.rx_valid   = rx_valid_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.parity_err = parity_err_q;
  assign bus.overrun    = overrun_q;
  assign bus.busy       = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_engine.sv
// Bench for uart_rx_engine: instance 0 without parity, instance 1 with even parity.
// The line model pushes {parity_err, frame_err, data} for every frame it sends; one
// compare process pops on each accept and watches held bytes and overrun pulses.
module tb_uart_rx_engine;
  localparam int unsigned CPB = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_rx_engine_if bus0 ();
  uart_rx_engine_if bus2 ();

  uart_rx_engine #(.CLK_HZ(1000000), .BAUD(100000), .DATA_BITS(8), .PARITY(0)) u_dut0 (
    .clk_clk     (clk),
    .reset_reset (rst),
    .bus         (bus0)
  );

  uart_rx_engine #(.CLK_HZ(1000000), .BAUD(100000), .DATA_BITS(8), .PARITY(2)) u_dut2 (
    .clk_clk     (clk),
    .reset_reset (rst),
    .bus         (bus2)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [9:0] expq0[$];
  logic [9:0] expq2[$];
  logic [9:0] got0[$];
  logic [9:0] got2[$];
  int exp_ovr [2];
  int ovr_seen [2];

  logic [7:0] data_a [2];
  logic       valid_a [2];
  logic       ready_a [2];
  logic       fe_a [2];
  logic       pe_a [2];
  logic       ovr_a [2];
  logic       busy_a [2];

  assign data_a[0]  = bus0.rx_data;     assign data_a[1]  = bus2.rx_data;
  assign valid_a[0] = bus0.rx_valid;    assign valid_a[1] = bus2.rx_valid;
  assign ready_a[0] = bus0.rx_ready;    assign ready_a[1] = bus2.rx_ready;
  assign fe_a[0]    = bus0.frame_err;   assign fe_a[1]    = bus2.frame_err;
  assign pe_a[0]    = bus0.parity_err;  assign pe_a[1]    = bus2.parity_err;
  assign ovr_a[0]   = bus0.overrun;     assign ovr_a[1]   = bus2.overrun;
  assign busy_a[0]  = bus0.busy;        assign busy_a[1]  = bus2.busy;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic int qsize(input int i);
    return (i == 0) ? expq0.size() : expq2.size();
  endfunction

  function automatic logic [9:0] log_at(input int i, input int idx);
    if (i == 0) return (idx < got0.size()) ? got0[idx] : 10'h3ff;
    return (idx < got2.size()) ? got2[idx] : 10'h3ff;
  endfunction

  // Compare process: every accept must match the oldest expected frame; a held byte must not move.
  logic       prev_v [2];
  logic       prev_acc [2];
  logic [9:0] prev_word [2];
  always @(negedge clk) begin
    logic [9:0] word;
    logic [9:0] e;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        prev_v[i]   = 1'b0;
        prev_acc[i] = 1'b0;
      end else begin
        word = {pe_a[i], fe_a[i], data_a[i]};
        if (prev_v[i] && !prev_acc[i])
          chk($sformatf("hold_stable%0d", i), {valid_a[i], word}, {1'b1, prev_word[i]});
        if (valid_a[i] && ready_a[i]) begin
          if (i == 0) got0.push_back(word); else got2.push_back(word);
          if (qsize(i) == 0) begin
            chk($sformatf("unexpected_byte%0d", i), 32'(word), 32'hffff_ffff);
          end else begin
            e = (i == 0) ? expq0.pop_front() : expq2.pop_front();
            chk($sformatf("accept%0d", i), word, e);
          end
        end
        if (ovr_a[i]) ovr_seen[i]++;
        prev_v[i]    = valid_a[i];
        prev_acc[i]  = valid_a[i] && ready_a[i];
        prev_word[i] = word;
      end
    end
  end

  task automatic hold(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_rxd(input int i, input logic v);
    if (i == 0) bus0.rxd = v; else bus2.rxd = v;
  endtask

  // Sends one frame at exactly CPB clocks per bit; instance 1 adds an even-parity bit.
  task automatic send_frame(input int i, input logic [7:0] data, input logic flip,
                            input logic stopb, input bit drop);
    logic pbit;
    logic [9:0] e;
    pbit = (^data) ^ flip;
    e = {(i == 1) ? (pbit != ^data) : 1'b0, ~stopb, data};
    if (drop) exp_ovr[i]++;
    else if (i == 0) expq0.push_back(e);
    else expq2.push_back(e);
    set_rxd(i, 1'b0);
    hold(CPB);
    for (int b = 0; b < 8; b++) begin
      set_rxd(i, data[b]);
      hold(CPB);
    end
    if (i == 1) begin
      set_rxd(i, pbit);
      hold(CPB);
    end
    set_rxd(i, stopb);
    hold(CPB);
    set_rxd(i, 1'b1);
  endtask

  task automatic wait_drain(input int i, input string name);
    bit done;
    done = 1'b0;
    for (int c = 0; c < 600 && !done; c++) begin
      if (qsize(i) == 0 && !valid_a[i] && !busy_a[i]) done = 1'b1;
      else hold(1);
    end
    chk(name, 32'(done), 32'd1);
  endtask

  task automatic rand_stream(input int i, input int n);
    logic stopb;
    logic flip;
    for (int k = 0; k < n; k++) begin
      stopb = ($urandom_range(0, 7) != 0);
      flip  = (i == 1) ? ($urandom_range(0, 3) == 0) : 1'b0;
      send_frame(i, 8'($urandom), flip, stopb, 1'b0);
      if (!stopb) hold(CPB);
      hold($urandom_range(0, 20));
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int base;
    int bcnt;
    bit done0;
    bit done1;
    bus0.rxd = 1'b1;  bus2.rxd = 1'b1;
    bus0.rx_ready = 1'b1;  bus2.rx_ready = 1'b1;
    exp_ovr = '{0, 0};
    ovr_seen = '{0, 0};

    // Reset state.
    hold(3);
    @(negedge clk);
    for (int i = 0; i < 2; i++)
      chk($sformatf("reset_outputs%0d", i),
          {valid_a[i], data_a[i], fe_a[i], pe_a[i], ovr_a[i], busy_a[i]}, 0);
    rst = 1'b0;
    hold(CPB);

    // Back-to-back 0x55, 0xA3.
    base = got0.size();
    send_frame(0, 8'h55, 1'b0, 1'b1, 1'b0);
    send_frame(0, 8'hA3, 1'b0, 1'b1, 1'b0);
    wait_drain(0, "drain_b2b");
    chk("b2b_first", log_at(0, base), 10'h055);
    chk("b2b_second", log_at(0, base + 1), 10'h0A3);
    chk("b2b_no_overrun", ovr_seen[0], 0);

    // Overrun while the consumer stalls.
    bus0.rx_ready = 1'b0;
    send_frame(0, 8'h12, 1'b0, 1'b1, 1'b0);
    send_frame(0, 8'h34, 1'b0, 1'b1, 1'b1);
    hold(5);
    chk("ovr_valid_held", {valid_a[0], data_a[0]}, {1'b1, 8'h12});
    chk("ovr_pulse_once", ovr_seen[0], 1);
    bus0.rx_ready = 1'b1;
    @(negedge clk);
    chk("ovr_accept_data", data_a[0], 8'h12);
    @(negedge clk);
    chk("ovr_valid_drop", valid_a[0], 1'b0);

    // Even parity: 0x07 needs parity bit 1.
    base = got2.size();
    send_frame(1, 8'h07, 1'b0, 1'b1, 1'b0);
    send_frame(1, 8'h07, 1'b1, 1'b1, 1'b0);
    wait_drain(1, "drain_parity");
    chk("parity_good", log_at(1, base), 10'h007);
    chk("parity_bad", log_at(1, base + 1), 10'h207);

    // Three-cycle glitch.
    base = got0.size();
    hold(CPB);
    set_rxd(0, 1'b0);
    hold(3);
    set_rxd(0, 1'b1);
    bcnt = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (busy_a[0]) bcnt++;
    end
    chk("glitch_busy_short", 32'(bcnt > 0 && bcnt < 10), 32'd1);
    chk("glitch_no_byte", got0.size() - base, 0);
    chk("glitch_idle", busy_a[0], 1'b0);

    // Break: 300 low cycles give one 0x00 with frame_err, then a clean 0x81.
    base = got0.size();
    expq0.push_back(10'h100);
    set_rxd(0, 1'b0);
    hold(250);
    chk("break_busy", busy_a[0], 1'b1);
    hold(50);
    set_rxd(0, 1'b1);
    hold(CPB);
    chk("break_released", busy_a[0], 1'b0);
    send_frame(0, 8'h81, 1'b0, 1'b1, 1'b0);
    wait_drain(0, "drain_break");
    chk("break_count", got0.size() - base, 2);
    chk("break_byte", log_at(0, base), 10'h100);
    chk("after_break", log_at(0, base + 1), 10'h081);

    // Reset in data bit 4 with a byte held.
    bus0.rx_ready = 1'b0;
    send_frame(0, 8'h3C, 1'b0, 1'b1, 1'b0);
    hold(CPB);
    set_rxd(0, 1'b0);
    hold(CPB);
    for (int b = 0; b < 4; b++) begin
      set_rxd(0, b[0]);
      hold(CPB);
    end
    set_rxd(0, 1'b1);
    hold(5);
    chk("pre_reset_held", {valid_a[0], data_a[0], busy_a[0]}, {1'b1, 8'h3C, 1'b1});
    rst = 1'b1;
    expq0.delete();
    #1;
    for (int i = 0; i < 2; i++)
      chk($sformatf("reset_async%0d", i),
          {valid_a[i], data_a[i], fe_a[i], pe_a[i], ovr_a[i], busy_a[i]}, 0);
    hold(3);
    rst = 1'b0;
    bus0.rx_ready = 1'b1;
    hold(CPB);
    base = got0.size();
    send_frame(0, 8'hC0, 1'b0, 1'b1, 1'b0);
    wait_drain(0, "drain_reset");
    chk("after_reset", log_at(0, base), 10'h0C0);

    // Randomized traffic on both instances with a randomly stalling consumer.
    done0 = 1'b0;
    done1 = 1'b0;
    fork
      begin rand_stream(0, 40); done0 = 1'b1; end
      begin rand_stream(1, 40); done1 = 1'b1; end
      while (!(done0 && done1)) begin
        bus0.rx_ready = 1'($urandom_range(0, 1));
        bus2.rx_ready = 1'($urandom_range(0, 1));
        hold(1);
      end
    join
    bus0.rx_ready = 1'b1;
    bus2.rx_ready = 1'b1;
    wait_drain(0, "drain_rand0");
    wait_drain(1, "drain_rand1");
    chk("overrun_count0", ovr_seen[0], exp_ovr[0]);
    chk("overrun_count1", ovr_seen[1], exp_ovr[1]);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
